// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for a LEGv8 datapath.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over one shared
// instruction/data memory with a req/ack handshake. Illegal opcodes and
// memory timeouts park the FSM in a sticky FAULT state until Reset.
// Optional build macro PERF_COUNTERS_EN adds CycleCount and InstrRetired.
module multicycle_controller #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic [2:0]  SignOp,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic [2:0]  State,
  output logic        Fault,
  output logic [1:0]  FaultCode
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrRetired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_ADDI = 3'd2,
    C_LDUR = 3'd3,
    C_STUR = 3'd4,
    C_CBZ  = 3'd5,
    C_B    = 3'd6,
    C_MOVZ = 3'd7
  } cls_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  // Last wait count that may still be followed by an ack; one more
  // unacknowledged cycle after this one means the request timed out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  // Map the 11-bit opcode field onto an instruction class.
  function automatic cls_t decode_class(input logic [10:0] op);
    cls_t c;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: c = C_R;
      11'b1001000100?: c = C_ADDI;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      11'b110100101??: c = C_MOVZ;
      default:         c = C_NONE;
    endcase
    return c;
  endfunction

  // Sign-extender control for each instruction class.
  function automatic logic [2:0] sign_op_for(input cls_t c);
    logic [2:0] s;
    case (c)
      C_ADDI:         s = 3'b000;
      C_LDUR, C_STUR: s = 3'b001;
      C_B:            s = 3'b010;
      C_CBZ:          s = 3'b011;
      C_MOVZ:         s = 3'b111;
      default:        s = 3'b000;
    endcase
    return s;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  cls_t       class_r;
  cls_t       dec_class_s;
  cls_t       op_class_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic [1:0] fault_code_r;
  logic [1:0] fault_code_nxt_s;
  logic       req_state_s;
  logic       timeout_s;

  logic       mem_req_s;
  logic       mem_write_s;
  logic       iord_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic [1:0] pc_src_s;
  logic       reg2loc_s;
  logic       alu_src_s;
  logic [1:0] alu_op_s;
  logic [2:0] sign_op_s;
  logic       reg_write_s;
  logic       memto_reg_s;

  assign dec_class_s = decode_class(Opcode);
  // In DECODE the class register is not loaded yet, so SignOp follows the
  // live opcode; afterwards it follows the latched class.
  assign op_class_s  = (state_r == S_DECODE) ? dec_class_s : class_r;
  assign req_state_s = (state_r == S_FETCH) || (state_r == S_MEM);
  assign timeout_s   = (wait_cnt_r == WAIT_LAST);

  // Next-state selection and fault-code capture.
  always_comb begin
    state_nxt_s      = state_r;
    fault_code_nxt_s = fault_code_r;
    case (state_r)
      S_FETCH: begin
        if (MemAck) begin
          state_nxt_s = S_DECODE;
        end else if (timeout_s) begin
          state_nxt_s      = S_FAULT;
          fault_code_nxt_s = FC_TIMEOUT;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_class_s == C_NONE) begin
          state_nxt_s      = S_FAULT;
          fault_code_nxt_s = FC_ILLEGAL;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_r)
          C_R, C_ADDI, C_MOVZ: state_nxt_s = S_WB;
          C_LDUR, C_STUR:      state_nxt_s = S_MEM;
          C_B, C_CBZ:          state_nxt_s = S_FETCH;
          default: begin
            state_nxt_s      = S_FAULT;
            fault_code_nxt_s = FC_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (MemAck) begin
          if (class_r == C_LDUR) begin
            state_nxt_s = S_WB;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end else if (timeout_s) begin
          state_nxt_s      = S_FAULT;
          fault_code_nxt_s = FC_TIMEOUT;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB:    state_nxt_s = S_FETCH;
      S_FAULT: state_nxt_s = S_FAULT;
      default: state_nxt_s = S_FAULT;
    endcase
  end

  // Wait counter: counts unacknowledged request cycles, clears on ack or exit.
  always_comb begin
    if (req_state_s && !MemAck && (state_nxt_s == state_r)) begin
      wait_cnt_nxt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_nxt_s = 8'd0;
    end
  end

  // State, class, wait counter and fault code registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r      <= S_FETCH;
      class_r      <= C_NONE;
      wait_cnt_r   <= 8'd0;
      fault_code_r <= FC_NONE;
    end else begin
      state_r      <= state_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      fault_code_r <= fault_code_nxt_s;
      if (state_r == S_DECODE) begin
        class_r <= dec_class_s;
      end else begin
        class_r <= class_r;
      end
    end
  end

  // Datapath control decode from state, class, MemAck and Zero.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    iord_s      = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_src_s    = 2'b00;
    reg2loc_s   = 1'b0;
    alu_src_s   = 1'b0;
    alu_op_s    = 2'b00;
    sign_op_s   = 3'b000;
    reg_write_s = 1'b0;
    memto_reg_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (MemAck) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
        end
      end
      S_DECODE: begin
        sign_op_s = sign_op_for(op_class_s);
      end
      S_EXEC: begin
        sign_op_s = sign_op_for(op_class_s);
        case (op_class_s)
          C_R: alu_op_s = 2'b10;
          C_ADDI: begin
            alu_src_s = 1'b1;
            alu_op_s  = 2'b00;
          end
          C_MOVZ: begin
            alu_src_s = 1'b1;
            alu_op_s  = 2'b01;
          end
          C_LDUR: alu_src_s = 1'b1;
          C_STUR: begin
            alu_src_s = 1'b1;
            reg2loc_s = 1'b1;
          end
          C_B: begin
            pc_write_s = 1'b1;
            pc_src_s   = 2'b10;
          end
          C_CBZ: begin
            reg2loc_s  = 1'b1;
            alu_op_s   = 2'b01;
            pc_src_s   = 2'b10;
            pc_write_s = Zero;
          end
          default: alu_op_s = 2'b00;
        endcase
      end
      S_MEM: begin
        sign_op_s   = sign_op_for(op_class_s);
        mem_req_s   = 1'b1;
        iord_s      = 1'b1;
        mem_write_s = (op_class_s == C_STUR);
      end
      S_WB: begin
        sign_op_s   = sign_op_for(op_class_s);
        reg_write_s = 1'b1;
        memto_reg_s = (op_class_s == C_LDUR);
      end
      default: mem_req_s = 1'b0;
    endcase
  end

  // Reset overrides every strobe so no memory or register write can leak out.
  assign MemReq    = Reset ? 1'b0   : mem_req_s;
  assign MemWrite  = Reset ? 1'b0   : mem_write_s;
  assign IorD      = Reset ? 1'b0   : iord_s;
  assign IRWrite   = Reset ? 1'b0   : ir_write_s;
  assign PCWrite   = Reset ? 1'b0   : pc_write_s;
  assign PCSrc     = Reset ? 2'b00  : pc_src_s;
  assign Reg2Loc   = Reset ? 1'b0   : reg2loc_s;
  assign ALUSrc    = Reset ? 1'b0   : alu_src_s;
  assign ALUOp     = Reset ? 2'b00  : alu_op_s;
  assign SignOp    = Reset ? 3'b000 : sign_op_s;
  assign RegWrite  = Reset ? 1'b0   : reg_write_s;
  assign MemtoReg  = Reset ? 1'b0   : memto_reg_s;
  assign State     = state_r;
  assign Fault     = Reset ? 1'b0   : (state_r == S_FAULT);
  assign FaultCode = Reset ? 2'b00  : fault_code_r;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_r;
  logic [31:0] instr_retired_r;
  logic        retire_s;

  assign retire_s = ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB))
                    && (state_nxt_s == S_FETCH);

  // Free-running cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_count_r   <= 32'd0;
      instr_retired_r <= 32'd0;
    end else begin
      if (state_r != S_FAULT) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
      if (retire_s) begin
        instr_retired_r <= instr_retired_r + 32'd1;
      end else begin
        instr_retired_r <= instr_retired_r;
      end
    end
  end

  assign CycleCount   = cycle_count_r;
  assign InstrRetired = instr_retired_r;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized checks of the LEGv8
// multi-cycle controller against a per-instruction phase model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg2loc;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] sign_op;
    logic       reg_write;
    logic       memto_reg;
    logic       fault;
    logic [1:0] fault_code;
  } ctrl_t;

  localparam int K_NONE = 0, K_R = 1, K_ADDI = 2, K_LDUR = 3, K_STUR = 4,
                 K_CBZ = 5, K_B = 6, K_MOVZ = 7;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = 11'd0;
  logic        Zero = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemReq, MemWrite, IorD, IRWrite, PCWrite, Reg2Loc, ALUSrc;
  logic        RegWrite, MemtoReg, Fault;
  logic [1:0]  PCSrc, ALUOp, FaultCode;
  logic [2:0]  SignOp, State;
  ctrl_t       obs;

  int checks = 0;
  int failures = 0;

  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000,
                             11'b10001010000, 11'b10101010000};

  multicycle_controller #(.WAIT_MAX(8)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemAck(MemAck),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .SignOp(SignOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .State(State), .Fault(Fault), .FaultCode(FaultCode)
  );

  always #5 CLK = ~CLK;

  assign obs = {MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc,
                ALUSrc, ALUOp, SignOp, RegWrite, MemtoReg, Fault, FaultCode};

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    if (op[10:1] == 10'b1001000100) return K_ADDI;
    if (op == 11'b11111000010) return K_LDUR;
    if (op == 11'b11111000000) return K_STUR;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    if (op[10:2] == 9'b110100101) return K_MOVZ;
    return K_NONE;
  endfunction

  function automatic logic [2:0] imm_kind(input int k);
    case (k)
      K_LDUR, K_STUR: return 3'b001;
      K_B:            return 3'b010;
      K_CBZ:          return 3'b011;
      K_MOVZ:         return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rand_op();
    int k = $urandom_range(0, 9);
    logic [10:0] r = 11'($urandom);
    case (k)
      0: return r_ops[$urandom_range(0, 3)];
      1: return {10'b1001000100, r[0]};
      2: return 11'b11111000010;
      3: return 11'b11111000000;
      4: return {8'b10110100, r[2:0]};
      5: return {6'b000101, r[4:0]};
      6: return {9'b110100101, r[1:0]};
      default: return r;
    endcase
  endfunction

  // One clock: drive inputs on the falling edge, then check outputs.
  task automatic cyc(input logic ack, input logic zero, input logic [2:0] est,
                     input ctrl_t exp, input string tag);
    @(negedge CLK);
    Reset = 1'b0;
    MemAck = ack;
    Zero = zero;
    #1;
    checks++;
    assert (State === est) else begin
      failures++;
      $error("FAIL %s state got=%0d want=%0d", tag, State, est);
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctrl got=%05h want=%05h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic ack);
    @(negedge CLK);
    Reset = 1'b1;
    MemAck = ack;
    Zero = rbit();
    #1;
    checks++;
    assert (obs[18:3] === 16'h0000) else begin
      failures++;
      $error("FAIL reset_ctrl got=%04h want=0000", obs[18:3]);
    end
  endtask

  task automatic fault_hold(input logic [1:0] code, input int n);
    ctrl_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.fault = 1'b1;
      e.fault_code = code;
      cyc(rbit(), rbit(), 3'd7, e, "fault");
    end
  endtask

  // Full instruction: fetch (wf waits), decode, exec, optional mem (wm
  // waits), optional writeback. Illegal opcodes fault, hold, then reset.
  task automatic run_instr(input logic [10:0] op, input int wf, input int wm,
                           input logic zero, input int hold_n);
    int k = classify(op);
    ctrl_t e;
    Opcode = op;
    for (int i = 0; i <= wf; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      if (i == wf) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      cyc(i == wf, rbit(), 3'd0, e, "fetch");
    end
    e = '0;
    e.sign_op = imm_kind(k);
    cyc(rbit(), rbit(), 3'd1, e, "decode");
    if (k == K_NONE) begin
      fault_hold(2'b10, hold_n);
      do_reset(rbit());
      return;
    end
    e = '0;
    e.sign_op = imm_kind(k);
    case (k)
      K_R:    e.alu_op = 2'b10;
      K_ADDI: e.alu_src = 1'b1;
      K_MOVZ: begin e.alu_src = 1'b1; e.alu_op = 2'b01; end
      K_LDUR: e.alu_src = 1'b1;
      K_STUR: begin e.alu_src = 1'b1; e.reg2loc = 1'b1; end
      K_B:    begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      K_CBZ:  begin e.reg2loc = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b10; e.pc_write = zero; end
      default: e.alu_op = 2'b00;
    endcase
    cyc(rbit(), zero, 3'd2, e, "exec");
    if (k == K_LDUR || k == K_STUR) begin
      for (int i = 0; i <= wm; i++) begin
        e = '0;
        e.sign_op = 3'b001;
        e.mem_req = 1'b1;
        e.iord = 1'b1;
        e.mem_write = (k == K_STUR);
        cyc(i == wm, rbit(), 3'd3, e, "mem");
      end
    end
    if (k == K_R || k == K_ADDI || k == K_MOVZ || k == K_LDUR) begin
      e = '0;
      e.sign_op = imm_kind(k);
      e.reg_write = 1'b1;
      e.memto_reg = (k == K_LDUR);
      cyc(rbit(), rbit(), 3'd4, e, "wb");
    end
  endtask

  initial begin
    ctrl_t e;
    do_reset(1'b1);
    do_reset(1'b0);

    // ADD, zero-wait memory
    run_instr(11'b10001011000, 0, 0, 1'b0, 0);
    // LDUR with two wait cycles on each access (9 cycles)
    run_instr(11'b11111000010, 2, 2, 1'b0, 0);
    // CBZ taken then not taken
    run_instr(11'b10110100101, 0, 0, 1'b1, 0);
    run_instr(11'b10110100010, 0, 0, 1'b0, 0);
    // Illegal opcode: sticky for 20 cycles, then reset back to FETCH
    run_instr(11'b11111111111, 0, 0, 1'b0, 20);
    run_instr(11'b00010100000, 0, 0, 1'b0, 0);

    // Fetch timeout after 8 unacknowledged request cycles
    Opcode = 11'b10001011000;
    for (int i = 0; i < 8; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      cyc(1'b0, rbit(), 3'd0, e, "fetch_to");
    end
    fault_hold(2'b01, 3);
    do_reset(1'b0);
    // Ack on the 8th cycle wins over timeout; long fetch + long mem wait
    run_instr(11'b10001011000, 7, 0, 1'b0, 0);
    run_instr(11'b11111000010, 7, 7, 1'b0, 0);

    // Memory-phase timeout on LDUR
    Opcode = 11'b11111000010;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, 1'b0, 3'd0, e, "fetch_m");
    e = '0; e.sign_op = 3'b001;
    cyc(1'b0, 1'b0, 3'd1, e, "decode_m");
    e.alu_src = 1'b1;
    cyc(1'b1, 1'b0, 3'd2, e, "exec_m");
    for (int i = 0; i < 8; i++) begin
      e = '0; e.sign_op = 3'b001; e.mem_req = 1'b1; e.iord = 1'b1;
      cyc(1'b0, rbit(), 3'd3, e, "mem_to");
    end
    fault_hold(2'b01, 2);
    do_reset(1'b1);

    // Reset in the middle of a STUR memory request
    Opcode = 11'b11111000000;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, 1'b0, 3'd0, e, "fetch_s");
    e = '0; e.sign_op = 3'b001;
    cyc(1'b0, 1'b0, 3'd1, e, "decode_s");
    e.alu_src = 1'b1; e.reg2loc = 1'b1;
    cyc(1'b0, 1'b0, 3'd2, e, "exec_s");
    e = '0; e.sign_op = 3'b001; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1;
    cyc(1'b0, 1'b0, 3'd3, e, "mem_s");
    do_reset(1'b1);
    run_instr(11'b11001011000, 0, 0, 1'b0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(rand_op(), $urandom_range(0, 7), $urandom_range(0, 7), rbit(), 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the LEGv8 datapath over multiple cycles: fetch, decode, execute, memory, writeback.
- Drives the sign-extender control (SignOp), ALU, register-file, PC and shared-memory strobes.
- Uses a req/ack handshake with one shared instruction/data memory.
- Detects illegal opcodes and memory timeouts, then parks in a sticky fault state.

Parameters:
WAIT_MAX, 8, max consecutive cycles MemReq may stay high without MemAck before timeout fault (range 1-255)

Ports:
CLK  input  1  clock, all state changes on rising edge
Reset  input  1  synchronous, active-high
Opcode  input  11  instr[31:21] from IR, valid from DECODE onward
Zero  input  1  ALU zero flag
MemAck  input  1  memory completes current request this cycle
MemReq  output  1  memory request
MemWrite  output  1  write qualifier for MemReq
IorD  output  1  0 = PC address, 1 = ALU address
IRWrite  output  1  load instruction register
PCWrite  output  1  load PC
PCSrc  output  2  00 PC+4, 10 branch target (datapath computes from OldPC)
Reg2Loc  output  1  read reg2 from instr[4:0]
ALUSrc  output  1  ALU B = BusImm
ALUOp  output  2  00 add, 01 pass B, 10 decode funct from Opcode
SignOp  output  3  SignExtender control: 000 I, 001 D, 010 B, 011 CBZ, 111 MOVZ
RegWrite  output  1  register-file write
MemtoReg  output  1  writeback from memory data
State  output  3  current state encoding
Fault  output  1  sticky fault flag
FaultCode  output  2  01 timeout, 10 illegal opcode

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Reset high at an edge (including mid-instruction or mid-request):
  - State=FETCH, class register=NONE, wait counter=0, Fault=0, FaultCode=00.
  - While Reset is high, every control output is forced 0.
- Control outputs are combinational from State, class register, MemAck and Zero. Any output not listed for a state is 0.
- FETCH:
  - MemReq=1, IorD=0.
  - On MemAck: IRWrite=1, PCWrite=1, PCSrc=00, go to DECODE. Otherwise stay.
- DECODE:
  - Latch class from Opcode: R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), ADDI (1001000100x), LDUR (11111000010), STUR (11111000000), CBZ (10110100xxx), B (000101xxxxx), MOVZ (110100101xx).
  - Unmatched opcode: go to FAULT with FaultCode=10. Otherwise go to EXEC.
  - SignOp is valid from DECODE through WB.
- EXEC:
  - R: ALUOp=10; go to WB.
  - ADDI: ALUSrc=1, ALUOp=00, SignOp=000; go to WB.
  - MOVZ: ALUSrc=1, ALUOp=01, SignOp=111; go to WB.
  - LDUR/STUR: ALUSrc=1, ALUOp=00, SignOp=001; Reg2Loc=1 for STUR; go to MEM.
  - B: SignOp=010, PCWrite=1, PCSrc=10; go to FETCH.
  - CBZ: SignOp=011, Reg2Loc=1, ALUOp=01, PCSrc=10, PCWrite=Zero; go to FETCH.
- MEM:
  - MemReq=1, IorD=1, MemWrite=1 for STUR.
  - On MemAck: LDUR goes to WB; STUR goes to FETCH.
- WB: RegWrite=1, MemtoReg=1 only for LDUR; go to FETCH.
- Handshake:
  - MemAck is sampled only while MemReq=1; otherwise it is ignored.
  - MemAck in the first request cycle means zero wait.
  - MemReq holds until ack.
- Timeout:
  - Counter increments each FETCH/MEM cycle without ack and clears on ack or state exit.
  - When the counter reaches WAIT_MAX without ack, next state is FAULT with FaultCode=01.
  - Ack in the same cycle the counter reaches WAIT_MAX wins: no fault.
- FAULT: all controls 0, Fault=1; held until Reset.
- Latency with zero-wait memory: B/CBZ 3 cycles, R/ADDI/MOVZ/STUR 4, LDUR 5.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- When defined: adds outputs CycleCount[31:0] and InstrRetired[31:0].
  - CycleCount increments every cycle not in FAULT.
  - InstrRetired increments on every transition into FETCH from EXEC, MEM or WB.
  - Both wrap at 2^32 and reset to 0.
- When undefined: these ports and their logic are absent.

Test Plan:
- ADD 10001011000 with MemAck in the first cycle -> states 0,1,2,4,0; IRWrite/PCWrite in cycle 0; ALUOp=10 in EXEC; RegWrite=1 in WB only.
- LDUR with 2 wait cycles on each access -> MemReq held 3 cycles per access, IorD=1 in MEM, SignOp=001, MemtoReg=1 in WB; 9 cycles total.
- CBZ with Zero=1 then Zero=0 -> PCWrite=1/PCSrc=10 in EXEC on the first, PCWrite=0 on the second; SignOp=011 and Reg2Loc=1 both times.
- Opcode 11111111111 -> FAULT after DECODE, Fault=1, FaultCode=10; persists 20 cycles; Reset clears to FETCH.
- WAIT_MAX=8, MemAck held low in FETCH -> FAULT with FaultCode=01 after 8 request cycles; a repeat with ack on the 8th cycle proceeds to DECODE with no fault.
- Reset asserted in MEM during STUR -> next cycle State=FETCH, MemReq=0 during reset; no spurious MemWrite after deassert.
